// File: rtl/rob_param.sv
// Parameterised reorder buffer: decode allocation, ALU/memory/branch writeback, in-order retire,
// store release handshake and mispredict flush. Define ROB_BYPASS_EN to enable the q1/q2 operand lookups.
module rob_param #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [4:0]        alloc_rd,
    input  logic [1:0]        alloc_kind,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb0_valid,
    input  logic [TAG_W-1:0]  wb0_tag,
    input  logic [DATA_W-1:0] wb0_value,
    input  logic              wb1_valid,
    input  logic [TAG_W-1:0]  wb1_tag,
    input  logic [DATA_W-1:0] wb1_value,
    input  logic              br_valid,
    input  logic [TAG_W-1:0]  br_tag,
    input  logic              br_mispredict,
    input  logic [DATA_W-1:0] br_target,
    output logic              commit_valid,
    output logic [4:0]        commit_rd,
    output logic [DATA_W-1:0] commit_value,
    output logic [TAG_W-1:0]  commit_tag,
    output logic              st_release_valid,
    output logic [TAG_W-1:0]  st_release_tag,
    input  logic              st_release_ack,
    output logic              flush,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [TAG_W:0]    count,
`ifdef ROB_BYPASS_EN
    input  logic [TAG_W-1:0]  q1_tag,
    input  logic [TAG_W-1:0]  q2_tag,
`endif
    output logic              q1_hit,
    output logic              q2_hit,
    output logic [DATA_W-1:0] q1_value,
    output logic [DATA_W-1:0] q2_value
);

    typedef enum logic [1:0] {
        ENT_FREE = 2'b00,
        ENT_BUSY = 2'b01,
        ENT_DONE = 2'b10
    } ent_state_e;

    localparam logic [1:0]   KIND_ALU    = 2'b00;
    localparam logic [1:0]   KIND_LOAD   = 2'b01;
    localparam logic [1:0]   KIND_STORE  = 2'b10;
    localparam logic [1:0]   KIND_BRANCH = 2'b11;
    localparam logic [TAG_W:0] FULL_CNT  = (TAG_W+1)'(DEPTH);

    ent_state_e          state_r   [DEPTH];
    logic [1:0]          kind_r    [DEPTH];
    logic [4:0]          rd_r      [DEPTH];
    logic [DATA_W-1:0]   value_r   [DEPTH];
    logic [DATA_W-1:0]   target_r  [DEPTH];
    logic [DEPTH-1:0]    mispred_r;

    logic [TAG_W-1:0]    head_r;
    logic [TAG_W-1:0]    tail_r;
    logic [TAG_W:0]      count_r;

    logic                commit_valid_r;
    logic [4:0]          commit_rd_r;
    logic [DATA_W-1:0]   commit_value_r;
    logic [TAG_W-1:0]    commit_tag_r;
    logic                flush_r;
    logic [DATA_W-1:0]   redirect_pc_r;

    logic                head_done_s;
    logic                head_store_s;
    logic                head_branch_s;
    logic                head_keeps_rd_s;
    logic                st_rel_s;
    logic                retire_s;
    logic                mispred_ret_s;
    logic                alloc_ready_s;
    logic                alloc_fire_s;
    logic [DEPTH-1:0]    wb_open_s;
    logic [DEPTH-1:0]    br_hit_s;
    logic [DEPTH-1:0]    wb1_hit_s;
    logic [DEPTH-1:0]    wb0_hit_s;

    // Head-of-buffer retire decision, taken from registered entry state only
    always_comb begin
        head_done_s     = (state_r[head_r] == ENT_DONE);
        head_store_s    = (kind_r[head_r] == KIND_STORE);
        head_branch_s   = (kind_r[head_r] == KIND_BRANCH);
        head_keeps_rd_s = (kind_r[head_r] == KIND_ALU) || (kind_r[head_r] == KIND_LOAD);
        st_rel_s        = head_done_s && head_store_s;
        retire_s        = head_done_s && (!head_store_s || st_release_ack);
        mispred_ret_s   = retire_s && head_branch_s && mispred_r[head_r];
        // Holding off decode while the mispredict retires keeps a just-issued tag from being lost to the flush
        alloc_ready_s   = (count_r != FULL_CNT) && !flush_r && !mispred_ret_s;
        alloc_fire_s    = alloc_valid && alloc_ready_s;
    end

    // Per-entry writeback match; branch beats memory beats ALU on the same tag
    always_comb begin
        wb_open_s = '0;
        br_hit_s  = '0;
        wb1_hit_s = '0;
        wb0_hit_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wb_open_s[i] = (state_r[i] == ENT_BUSY) && !flush_r;
            br_hit_s[i]  = wb_open_s[i] && br_valid && (br_tag == TAG_W'(i));
            wb1_hit_s[i] = wb_open_s[i] && wb1_valid && (wb1_tag == TAG_W'(i)) && !br_hit_s[i];
            wb0_hit_s[i] = wb_open_s[i] && wb0_valid && (wb0_tag == TAG_W'(i))
                           && !br_hit_s[i] && !wb1_hit_s[i];
        end
    end

    // Entry lifecycle: FREE -> BUSY on allocation, BUSY -> DONE on writeback, DONE -> FREE on retire
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_r[i]  <= ENT_FREE;
                kind_r[i]   <= 2'b00;
                rd_r[i]     <= 5'd0;
                value_r[i]  <= '0;
                target_r[i] <= '0;
            end
            mispred_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mispred_ret_s) begin
                    state_r[i]   <= ENT_FREE;
                    mispred_r[i] <= 1'b0;
                end else if (retire_s && (head_r == TAG_W'(i))) begin
                    state_r[i]   <= ENT_FREE;
                end else if (alloc_fire_s && (tail_r == TAG_W'(i))) begin
                    state_r[i]   <= ENT_BUSY;
                    kind_r[i]    <= alloc_kind;
                    rd_r[i]      <= alloc_rd;
                    value_r[i]   <= '0;
                    target_r[i]  <= '0;
                    mispred_r[i] <= 1'b0;
                end else if (br_hit_s[i]) begin
                    state_r[i]   <= ENT_DONE;
                    mispred_r[i] <= br_mispredict;
                    target_r[i]  <= br_target;
                end else if (wb1_hit_s[i]) begin
                    state_r[i]   <= ENT_DONE;
                    value_r[i]   <= wb1_value;
                end else if (wb0_hit_s[i]) begin
                    state_r[i]   <= ENT_DONE;
                    value_r[i]   <= wb0_value;
                end
            end
        end
    end

    // Head/tail pointers and occupancy; occupancy alone decides full and empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (mispred_ret_s) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (retire_s) begin
                head_r <= head_r + TAG_W'(1);
            end
            if (alloc_fire_s) begin
                tail_r <= tail_r + TAG_W'(1);
            end
            case ({alloc_fire_s, retire_s})
                2'b10:   count_r <= count_r + (TAG_W+1)'(1);
                2'b01:   count_r <= count_r - (TAG_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered retire pulse, flush pulse and redirect target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_valid_r <= 1'b0;
            commit_rd_r    <= 5'd0;
            commit_value_r <= '0;
            commit_tag_r   <= '0;
            flush_r        <= 1'b0;
            redirect_pc_r  <= '0;
        end else begin
            commit_valid_r <= retire_s;
            flush_r        <= mispred_ret_s;
            if (retire_s) begin
                commit_tag_r   <= head_r;
                commit_rd_r    <= head_keeps_rd_s ? rd_r[head_r] : 5'd0;
                commit_value_r <= head_keeps_rd_s ? value_r[head_r] : '0;
            end
            if (mispred_ret_s) begin
                redirect_pc_r <= target_r[head_r];
            end
        end
    end

    assign alloc_ready      = alloc_ready_s;
    assign alloc_tag        = tail_r;
    assign commit_valid     = commit_valid_r;
    assign commit_rd        = commit_rd_r;
    assign commit_value     = commit_value_r;
    assign commit_tag       = commit_tag_r;
    assign st_release_valid = st_rel_s;
    assign st_release_tag   = st_rel_s ? head_r : '0;
    assign flush            = flush_r;
    assign redirect_pc      = redirect_pc_r;
    assign count            = count_r;

`ifdef ROB_BYPASS_EN
    // Returns {hit, value}: completed entry, or a writeback landing on a busy entry this cycle
    function automatic logic [DATA_W:0] bypass_lookup(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] res;
        if (state_r[tag] == ENT_DONE) begin
            res = {1'b1, value_r[tag]};
        end else if (wb_open_s[tag] && wb1_valid && (wb1_tag == tag)) begin
            res = {1'b1, wb1_value};
        end else if (wb_open_s[tag] && wb0_valid && (wb0_tag == tag)) begin
            res = {1'b1, wb0_value};
        end else begin
            res = '0;
        end
        return res;
    endfunction

    // Operand lookups for the rename stage
    always_comb begin
        {q1_hit, q1_value} = bypass_lookup(q1_tag);
        {q2_hit, q2_value} = bypass_lookup(q2_tag);
    end
`else
    assign q1_hit   = 1'b0;
    assign q2_hit   = 1'b0;
    assign q1_value = '0;
    assign q2_value = '0;
`endif

endmodule

// File: tb/tb_rob_param.sv
// Scoreboard bench for rob_param: a program-order queue model predicts commits, flushes and
// handshake outputs; a separate monitor checks every commit pulse against the expected queue.
module tb_rob_param;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [4:0]        alloc_rd;
    logic [1:0]        alloc_kind;
    logic [TAG_W-1:0]  alloc_tag;
    logic              wb0_valid;
    logic [TAG_W-1:0]  wb0_tag;
    logic [DATA_W-1:0] wb0_value;
    logic              wb1_valid;
    logic [TAG_W-1:0]  wb1_tag;
    logic [DATA_W-1:0] wb1_value;
    logic              br_valid;
    logic [TAG_W-1:0]  br_tag;
    logic              br_mispredict;
    logic [DATA_W-1:0] br_target;
    logic              commit_valid;
    logic [4:0]        commit_rd;
    logic [DATA_W-1:0] commit_value;
    logic [TAG_W-1:0]  commit_tag;
    logic              st_release_valid;
    logic [TAG_W-1:0]  st_release_tag;
    logic              st_release_ack;
    logic              flush;
    logic [DATA_W-1:0] redirect_pc;
    logic [TAG_W:0]    count;
`ifdef ROB_BYPASS_EN
    logic [TAG_W-1:0]  q1_tag;
    logic [TAG_W-1:0]  q2_tag;
`endif
    logic              q1_hit;
    logic              q2_hit;
    logic [DATA_W-1:0] q1_value;
    logic [DATA_W-1:0] q2_value;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
        .alloc_kind(alloc_kind), .alloc_tag(alloc_tag),
        .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_value(wb0_value),
        .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_value(wb1_value),
        .br_valid(br_valid), .br_tag(br_tag), .br_mispredict(br_mispredict), .br_target(br_target),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_tag(commit_tag),
        .st_release_valid(st_release_valid), .st_release_tag(st_release_tag),
        .st_release_ack(st_release_ack),
        .flush(flush), .redirect_pc(redirect_pc), .count(count),
`ifdef ROB_BYPASS_EN
        .q1_tag(q1_tag), .q2_tag(q2_tag),
`endif
        .q1_hit(q1_hit), .q2_hit(q2_hit), .q1_value(q1_value), .q2_value(q2_value)
    );

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [4:0]        rd;
        logic [1:0]        kind;
        bit                done;
        bit                mis;
        logic [DATA_W-1:0] target;
        logic [DATA_W-1:0] value;
    } ent_t;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [4:0]        rd;
        logic [1:0]        kind;
        logic [DATA_W-1:0] value;
        bit                fl;
        logic [DATA_W-1:0] pc;
    } cmt_t;

    ent_t rob_q[$];
    cmt_t exp_q[$];
    int   next_tag;
    bit   flush_pend;
    bit   mon_en;
    int   n_checks;
    int   n_pass;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    endfunction

    task automatic idle();
        alloc_valid = 1'b0; alloc_rd = 5'd0; alloc_kind = 2'b00;
        wb0_valid = 1'b0; wb0_tag = '0; wb0_value = '0;
        wb1_valid = 1'b0; wb1_tag = '0; wb1_value = '0;
        br_valid = 1'b0; br_tag = '0; br_mispredict = 1'b0; br_target = '0;
        st_release_ack = 1'b0;
`ifdef ROB_BYPASS_EN
        q1_tag = '0; q2_tag = '0;
`endif
    endtask

`ifdef ROB_BYPASS_EN
    function automatic void exp_lookup(input logic [TAG_W-1:0] t, output bit hit, output logic [DATA_W-1:0] v);
        hit = 1'b0; v = '0;
        foreach (rob_q[j]) begin
            if (rob_q[j].tag == t) begin
                if (rob_q[j].done) begin hit = 1'b1; v = rob_q[j].value; end
                else if (!flush_pend && wb1_valid && wb1_tag == t) begin hit = 1'b1; v = wb1_value; end
                else if (!flush_pend && wb0_valid && wb0_tag == t) begin hit = 1'b1; v = wb0_value; end
            end
        end
    endfunction
`endif

    // Called just after a falling edge with this cycle's inputs already driven.
    task automatic step();
        ent_t h;
        ent_t e;
        cmt_t c;
        bit   has_h, exp_st, retire, mret, exp_ready;
`ifdef ROB_BYPASS_EN
        bit   eh;
        logic [DATA_W-1:0] ev;
`endif
        #1;
        has_h = (rob_q.size() > 0);
        if (has_h) h = rob_q[0];
        exp_st    = has_h && h.done && (h.kind == 2'b10);
        retire    = has_h && h.done && ((h.kind != 2'b10) || st_release_ack);
        mret      = retire && (h.kind == 2'b11) && h.mis;
        exp_ready = (rob_q.size() < DEPTH) && !flush_pend && !mret;
        check("alloc_ready", 64'(alloc_ready), 64'(exp_ready));
        if (exp_ready) check("alloc_tag", 64'(alloc_tag), 64'(next_tag));
        check("count", 64'(count), 64'(rob_q.size()));
        check("st_release_valid", 64'(st_release_valid), 64'(exp_st));
        if (exp_st) check("st_release_tag", 64'(st_release_tag), 64'(h.tag));
`ifdef ROB_BYPASS_EN
        exp_lookup(q1_tag, eh, ev);
        check("q1_hit", 64'(q1_hit), 64'(eh));
        if (eh) check("q1_value", 64'(q1_value), 64'(ev));
        exp_lookup(q2_tag, eh, ev);
        check("q2_hit", 64'(q2_hit), 64'(eh));
        if (eh) check("q2_value", 64'(q2_value), 64'(ev));
`else
        check("q1_hit_tied", 64'(q1_hit), 64'(0));
        check("q2_value_tied", 64'(q2_value), 64'(0));
`endif
        if (retire) begin
            c.tag = h.tag; c.kind = h.kind;
            c.rd = (h.kind < 2'd2) ? h.rd : 5'd0;
            c.value = h.value; c.fl = mret; c.pc = h.target;
            exp_q.push_back(c);
        end
        if (!flush_pend) begin
            foreach (rob_q[j]) begin
                if (!rob_q[j].done) begin
                    if (br_valid && br_tag == rob_q[j].tag) begin
                        rob_q[j].done = 1'b1; rob_q[j].mis = br_mispredict; rob_q[j].target = br_target;
                    end else if (wb1_valid && wb1_tag == rob_q[j].tag) begin
                        rob_q[j].done = 1'b1; rob_q[j].value = wb1_value;
                    end else if (wb0_valid && wb0_tag == rob_q[j].tag) begin
                        rob_q[j].done = 1'b1; rob_q[j].value = wb0_value;
                    end
                end
            end
        end
        if (retire) rob_q.delete(0);
        if (mret) begin
            rob_q.delete();
            next_tag   = 0;
            flush_pend = 1'b1;
        end else begin
            flush_pend = 1'b0;
            if (alloc_valid && exp_ready) begin
                e.tag = TAG_W'(next_tag); e.rd = alloc_rd; e.kind = alloc_kind;
                e.done = 1'b0; e.mis = 1'b0; e.target = '0; e.value = '0;
                rob_q.push_back(e);
                next_tag = (next_tag + 1) % DEPTH;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        idle();
        rob_q.delete(); exp_q.delete();
        next_tag = 0; flush_pend = 1'b0;
        #1;
        check("rst_commit_valid", 64'(commit_valid), 64'(0));
        check("rst_flush", 64'(flush), 64'(0));
        check("rst_st_release_valid", 64'(st_release_valid), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_commit_fields", {27'(0), commit_rd, 29'(commit_tag), 3'(0)}, 64'(0));
        check("rst_commit_value", 64'(commit_value), 64'(0));
        check("rst_redirect_pc", 64'(redirect_pc), 64'(0));
        check("rst_st_release_tag", 64'(st_release_tag), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic [1:0] kind);
        idle(); alloc_valid = 1'b1; alloc_rd = rd; alloc_kind = kind; step();
    endtask

    task automatic do_wb0(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
        idle(); wb0_valid = 1'b1; wb0_tag = t; wb0_value = v; step();
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) begin idle(); step(); end
    endtask

    task automatic rand_tag(output logic vld, output logic [TAG_W-1:0] t, input int odds);
        if (rob_q.size() > 0 && $urandom_range(odds - 1) == 0) begin
            vld = 1'b1;
            t = rob_q[$urandom_range(rob_q.size() - 1)].tag;
        end else begin
            vld = ($urandom_range(7) == 0);
            t = TAG_W'($urandom_range(DEPTH - 1));
        end
    endtask

    // Monitor: every commit pulse must match the oldest expected retire
    initial begin
        cmt_t c;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rst) begin
                if (commit_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_commit", 64'(commit_valid), 64'(0));
                    end else begin
                        c = exp_q.pop_front();
                        check("commit_tag", 64'(commit_tag), 64'(c.tag));
                        check("commit_rd", 64'(commit_rd), 64'(c.rd));
                        if (c.kind < 2'd2) check("commit_value", 64'(commit_value), 64'(c.value));
                        check("commit_flush", 64'(flush), 64'(c.fl));
                        if (c.fl) check("redirect_pc", 64'(redirect_pc), 64'(c.pc));
                    end
                end else begin
                    if (exp_q.size() != 0) begin
                        check("missing_commit", 64'(commit_valid), 64'(1));
                        exp_q.delete(0);
                    end
                    check("flush_idle", 64'(flush), 64'(0));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0; mon_en = 1'b0;
        next_tag = 0; flush_pend = 1'b0;
        rst = 1'b1;
        idle();
        @(negedge clk);

        // Out-of-order completion, in-order commit
        do_reset();
        for (int r = 1; r <= 3; r++) do_alloc(5'(r), 2'b00);
        do_wb0(3'd2, 32'h22);
        do_wb0(3'd0, 32'h11);
        do_wb0(3'd1, 32'h33);
        idle_steps(4);

        // Fill to DEPTH, refuse one more, retire one and wrap the tail
        do_reset();
        for (int r = 0; r < DEPTH; r++) do_alloc(5'(r + 1), 2'b00);
        do_alloc(5'd20, 2'b00);
        do_wb0(3'd0, 32'hA0);
        idle_steps(1);
        do_alloc(5'd9, 2'b01);
        for (int t = 1; t <= DEPTH; t++) do_wb0(TAG_W'(t % DEPTH), 32'hB0 + 32'(t));
        idle_steps(3);

        // Store held at head until the LSU acknowledges
        do_reset();
        do_alloc(5'd5, 2'b10);
        idle(); wb1_valid = 1'b1; wb1_tag = 3'd0; wb1_value = 32'h77; step();
        idle_steps(5);
        idle(); st_release_ack = 1'b1; step();
        idle_steps(2);

        // Mispredicted branch flushes younger completed work
        do_reset();
        do_alloc(5'd1, 2'b00);
        do_alloc(5'd2, 2'b11);
        do_alloc(5'd3, 2'b00);
        do_alloc(5'd4, 2'b00);
        idle(); br_valid = 1'b1; br_tag = 3'd1; br_mispredict = 1'b1; br_target = 32'h1000;
        wb0_valid = 1'b1; wb0_tag = 3'd2; wb0_value = 32'h2; step();
        do_wb0(3'd3, 32'h3);
        do_wb0(3'd0, 32'h10);
        idle_steps(4);

        // Memory writeback beats ALU writeback on the same tag
        do_reset();
        do_alloc(5'd7, 2'b00);
        idle(); wb0_valid = 1'b1; wb0_tag = 3'd0; wb0_value = 32'hA;
        wb1_valid = 1'b1; wb1_tag = 3'd0; wb1_value = 32'hB; step();
        idle_steps(2);

        // Randomized traffic with one mid-run reset
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) do_reset();
            idle();
            alloc_valid = ($urandom_range(3) != 0);
            alloc_rd    = 5'($urandom_range(31));
            alloc_kind  = 2'($urandom_range(3));
            rand_tag(wb0_valid, wb0_tag, 2);
            wb0_value = $urandom();
            rand_tag(wb1_valid, wb1_tag, 3);
            wb1_value = $urandom();
            rand_tag(br_valid, br_tag, 4);
            br_mispredict  = ($urandom_range(5) == 0);
            br_target      = $urandom();
            st_release_ack = ($urandom_range(2) == 0);
`ifdef ROB_BYPASS_EN
            q1_tag = TAG_W'($urandom_range(DEPTH - 1));
            q2_tag = TAG_W'($urandom_range(DEPTH - 1));
`endif
            step();
        end
        idle_steps(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
